i2c_slave_core: RTL



---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_sync_filter.sv | 59 +++++
 rtl/i2c_slave_core.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target core.
package i2c_pkg;

  // Target-side protocol states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    RX_BYTE   = 3'd3,
    RX_ACK    = 3'd4,
    TX_BYTE   = 3'd5,
    TX_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } i2c_slv_state_t;

  // Bus-level meaning of the ninth (acknowledge) bit and the R/W bit.
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_sync_filter.sv
// Synchroniser, glitch filter and edge detector for one open-drain bus line.
// The filtered level moves 2+FILT_LEN clk cycles after a stable bus change.
module i2c_sync_filter #(
  parameter int   FILT_LEN = 3,
  parameter logic RST_VAL  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Filter: accept the synchronised level only after it has differed from
  // the current filtered level for FILT_LEN consecutive cycles.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned (no latch).
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(FILT_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Sync chain, filter state and previous-level register; idle bus is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      filt_q  <= RST_VAL;
      prev_q  <= RST_VAL;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples its input as it was before this edge.
      sync1_q <= in_raw;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      prev_q  <= filt_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level = filt_q;
  assign rise  = filt_q & ~prev_q;
  assign fall  = ~filt_q & prev_q;

endmodule

// File: rtl/i2c_slave_core.sv
// I2C target: decodes START/STOP, matches a 7-bit address, streams written
// bytes out and read bytes in. SDA is driven open-drain via sda_oe only.
module i2c_slave_core
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h2a,
  parameter int         FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_cond, stop_cond;

  i2c_slv_state_t state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     byte_in;
  logic           rw_q, rw_d;
  logic           sda_oe_q, sda_oe_d;
  logic           busy_q, busy_d;
  logic [7:0]     rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;
  logic           start_det_q, start_det_d;
  logic           stop_det_q, stop_det_d;

  i2c_sync_filter #(.FILT_LEN(FILT_LEN), .RST_VAL(1'b1)) u_scl_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_raw (scl_i),
    .level  (scl_lvl),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  i2c_sync_filter #(.FILT_LEN(FILT_LEN), .RST_VAL(1'b1)) u_sda_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_raw (sda_i),
    .level  (sda_lvl),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  // SDA may only move while SCL is high at START/STOP; both edges cannot coincide.
  assign start_cond = sda_fall & scl_lvl;
  assign stop_cond  = sda_rise & scl_lvl;

  // Protocol state machine; all bus decisions are taken on filtered SCL edges.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;
    tx_req      = 1'b0;
    byte_in     = {shift_q[6:0], sda_lvl};

    if (stop_cond) begin
      state_d    = IDLE;
      bit_cnt_d  = 3'd0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
    end else if (start_cond) begin
      // Also covers repeated START: any driven ACK or data bit is dropped now.
      state_d     = ADDR;
      bit_cnt_d   = 3'd0;
      sda_oe_d    = 1'b0;
      start_det_d = 1'b1;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_in[7:1] == I2C_ADDR) begin
                state_d = ADDR_ACK;
                rw_d    = byte_in[0];
                busy_d  = 1'b1;
              end else begin
                state_d = WAIT_STOP;
                busy_d  = 1'b0;
              end
            end
          end
        end

        ADDR_ACK: begin
          // First fall opens the ACK slot, second fall closes it.
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q == I2C_RW_READ) begin
              tx_req    = 1'b1;
              shift_d   = tx_data;
              sda_oe_d  = ~tx_data[7];
              bit_cnt_d = 3'd0;
              state_d   = TX_BYTE;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = RX_BYTE;
            end
          end
        end

        RX_BYTE: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = byte_in;
              rx_valid_d = 1'b1;
              state_d    = RX_ACK;
            end
          end
        end

        RX_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = RX_BYTE;
            end
          end
        end

        TX_BYTE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              // Eighth bit done: hand SDA to the master for its ACK/NACK.
              sda_oe_d = 1'b0;
              state_d  = TX_ACK;
            end else begin
              // Rotate rather than zero-fill; the bit wrapping into [0] is never driven.
              shift_d  = {shift_q[6:0], shift_q[7]};
              sda_oe_d = ~shift_q[6];
            end
          end
        end

        TX_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == I2C_NACK) begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end else begin
              bit_cnt_d = 3'd1;
            end
          end else if (scl_fall && bit_cnt_q == 3'd1) begin
            tx_req    = 1'b1;
            shift_d   = tx_data;
            sda_oe_d  = ~tx_data[7];
            bit_cnt_d = 3'd0;
            state_d   = TX_BYTE;
          end
        end

        default: ;
      endcase
    end
  end

  // State and output registers; reset releases SDA without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      rw_q        <= I2C_RW_WRITE;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;

endmodule
